// File: rtl/div_fsm.sv
// Sequential restoring divider: one quotient bit per SHIFT/SUB pair.
// Ports: clk, rst (async high); a_in/b_in/id_div + d_valid_data/d_ready_data
//   operand handshake; start pops the input FIFO; d_valid_res/result_div
//   to the output FIFO, held until div_written; ready_f_res = FIFO not full.
module div_fsm #(
  parameter int DATA_SIZE     = 16,
  parameter int DIV_DATA_SIZE = DATA_SIZE / 2,
  parameter int ID_SIZE       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIV_DATA_SIZE-1:0]     a_in,
  input  logic [DIV_DATA_SIZE-1:0]     b_in,
  input  logic [ID_SIZE-1:0]           id_div,
  input  logic                         d_valid_data,
  input  logic                         ready_f_res,
  input  logic                         div_written,
  output logic                         d_ready_data,
  output logic                         d_valid_res,
  output logic [DATA_SIZE+ID_SIZE:0]   result_div,
  output logic                         start
);
  localparam int N  = DIV_DATA_SIZE;
  localparam int CW = $clog2(DIV_DATA_SIZE) + 1;

  typedef enum logic [2:0] {
    IDLE,
    INITIAL,
    SHIFT,
    SUB,
    SAVE
  } state_t;

  state_t          state_q;
  logic [N-1:0]    q_q;
  logic [N-1:0]    r_q;
  logic [N-1:0]    d_q;
  logic [ID_SIZE-1:0] id_q;
  logic            dz_q;
  logic [CW-1:0]   cnt_q;
  logic            start_q;
  logic            valid_q;

  logic [N:0]      t_d;
  logic            accept_d;

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign d_ready_data = ~rst & (state_q == IDLE) & ready_f_res;
  assign accept_d     = d_valid_data & d_ready_data;

  // Trial subtraction; t_d[N] is the borrow.
  assign t_d = {1'b0, r_q} - {1'b0, d_q};

  assign d_valid_res = valid_q;
  assign start       = start_q;
  assign result_div  = {id_q, dz_q, r_q, q_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      id_q    <= '0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_d) begin
            q_q     <= a_in;
            d_q     <= b_in;
            id_q    <= id_div;
            r_q     <= '0;
            cnt_q   <= '0;
            start_q <= 1'b1;
            state_q <= INITIAL;
          end
        end
        INITIAL: begin
          if (d_q == '0) begin
            q_q     <= '1;
            r_q     <= q_q;
            dz_q    <= 1'b1;
            valid_q <= 1'b1;
            state_q <= SAVE;
          end else begin
            dz_q    <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // After k shifts R < 2^k, so the bit shifted out of R is always 0.
          {r_q, q_q} <= {r_q[N-2:0], q_q, 1'b0};
          cnt_q      <= cnt_q + 1'b1;
          state_q    <= SUB;
        end
        SUB: begin
          if (!t_d[N]) begin
            r_q    <= t_d[N-1:0];
            q_q[0] <= 1'b1;
          end
          if (cnt_q == CW'(N)) begin
            valid_q <= 1'b1;
            state_q <= SAVE;
          end else begin
            state_q <= SHIFT;
          end
        end
        SAVE: begin
          if (div_written) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_fsm.sv
// Scoreboard bench for div_fsm: directed vectors, backpressure,
// mid-operation reset and a random regression.
module tb_div_fsm;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_in, b_in, id_div;
  logic        d_valid_data, ready_f_res, div_written;
  logic        d_ready_data, d_valid_res, start;
  logic [24:0] result_div;

  div_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .a_in         (a_in),
    .b_in         (b_in),
    .id_div       (id_div),
    .d_valid_data (d_valid_data),
    .ready_f_res  (ready_f_res),
    .div_written  (div_written),
    .d_ready_data (d_ready_data),
    .d_valid_res  (d_valid_res),
    .result_div   (result_div),
    .start        (start)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc = -100;
  bit busy = 0;
  bit vprev = 0;
  logic [24:0] held;

  logic [24:0] exp_q[$];
  int          lat_q[$];
  int          acc_t_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic logic [24:0] mk(input logic [7:0] id, input logic dz,
                                     input logic [7:0] r, input logic [7:0] q);
    return {id, dz, r, q};
  endfunction

  // Monitor: start pulses, busy acceptance, result/latency, hold.
  always @(negedge clk) begin
    bit exp_st;
    if (rst) begin
      busy = 0;
      vprev = 0;
      last_acc = -100;
      acc_t_q.delete();
    end else begin
      exp_st = (cyc == last_acc + 1);
      if (start || exp_st) check("start_pulse", start, exp_st);
      if (d_valid_data && d_ready_data) begin
        check("accept_while_busy", busy, 0);
        busy = 1;
        last_acc = cyc;
        acc_t_q.push_back(cyc);
        acc_cnt++;
      end
      if (d_valid_res && !vprev) begin
        if (exp_q.size() == 0 || acc_t_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("result", result_div, exp_q.pop_front());
          check("latency", cyc - acc_t_q.pop_front(), lat_q.pop_front());
        end
        held = result_div;
      end else if (d_valid_res) begin
        check("result_hold", result_div, held);
      end
      if (d_valid_res && div_written) busy = 0;
      vprev = d_valid_res;
    end
  end

  task automatic finish_op(input int a0, input int wdly);
    int n;
    n = 0;
    while (acc_cnt == a0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (acc_cnt == a0) begin
      check("accept_timeout", 0, 1);
      d_valid_data = 0;
      return;
    end
    n = 0;
    while (!d_valid_res && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!d_valid_res) begin
      check("result_timeout", 0, 1);
      d_valid_data = 0;
      return;
    end
    repeat (wdly) @(negedge clk);
    @(posedge clk); #1;
    div_written = 1;
    @(posedge clk); #1;
    div_written = 0;
    d_valid_data = 0;
    @(negedge clk);
    check("valid_drop", d_valid_res, 0);
    check("ready_back", d_ready_data, 1);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] id, input logic [24:0] e,
                    input int lat, input int wdly);
    int a0;
    @(posedge clk); #1;
    a_in = a;
    b_in = b;
    id_div = id;
    d_valid_data = 1;
    exp_q.push_back(e);
    lat_q.push_back(lat);
    a0 = acc_cnt;
    finish_op(a0, wdly);
  endtask

  initial begin
    int a0, c0;
    logic [7:0] ra, rb, rid;
    rst = 1;
    a_in = 0;
    b_in = 0;
    id_div = 0;
    d_valid_data = 0;
    ready_f_res = 1;
    div_written = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", d_ready_data, 0);
    check("rst_valid", d_valid_res, 0);
    check("rst_start", start, 0);
    check("rst_result", result_div, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("idle_ready", d_ready_data, 1);

    op(8'd100, 8'd7, 8'h3C, mk(8'h3C, 0, 8'h02, 8'h0E), 18, 4);
    op(8'd255, 8'd1, 8'h01, mk(8'h01, 0, 8'h00, 8'hFF), 18, 0);
    op(8'd5, 8'd9, 8'h02, mk(8'h02, 0, 8'h05, 8'h00), 18, 1);
    op(8'd255, 8'd255, 8'h03, mk(8'h03, 0, 8'h00, 8'h01), 18, 2);
    op(8'h2A, 8'd0, 8'h11, mk(8'h11, 1, 8'h2A, 8'hFF), 2, 1);

    // Backpressure: output FIFO full for 5 cycles.
    @(posedge clk); #1;
    ready_f_res = 0;
    a_in = 8'd50;
    b_in = 8'd5;
    id_div = 8'h05;
    d_valid_data = 1;
    exp_q.push_back(mk(8'h05, 0, 8'h00, 8'h0A));
    lat_q.push_back(18);
    a0 = acc_cnt;
    repeat (5) begin
      @(negedge clk); #1;
      check("bp_ready", d_ready_data, 0);
      check("bp_start", start, 0);
    end
    check("bp_no_accept", acc_cnt, a0);
    @(posedge clk); #1;
    ready_f_res = 1;
    finish_op(a0, 2);

    // Reset during the 4th SUB of 200/3; no result expected.
    @(posedge clk); #1;
    a_in = 8'd200;
    b_in = 8'd3;
    id_div = 8'h55;
    d_valid_data = 1;
    a0 = acc_cnt;
    c0 = 0;
    while (acc_cnt == a0 && c0 < 50) begin
      @(negedge clk); #1;
      c0++;
    end
    check("rst_op_accept", acc_cnt, a0 + 1);
    c0 = last_acc;
    while (cyc < c0 + 9) @(negedge clk);
    #1;
    rst = 1;
    d_valid_data = 0;
    #1;
    check("midrst_ready", d_ready_data, 0);
    check("midrst_valid", d_valid_res, 0);
    check("midrst_start", start, 0);
    check("midrst_result", result_div, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("postrst_idle", d_ready_data, 1);
    op(8'd200, 8'd3, 8'h77, mk(8'h77, 0, 8'd2, 8'd66), 18, 0);

    // Random regression against a / and % reference.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 16 == 0) rb = 0;
      rid = 8'(i);
      if (rb == 0)
        op(ra, rb, rid, mk(rid, 1, ra, 8'hFF), 2,
           int'($urandom_range(0, 5)));
      else
        op(ra, rb, rid, mk(rid, 0, ra % rb, ra / rb), 18,
           int'($urandom_range(0, 5)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_fsm.md
Name: div_fsm

Overview:
- Sequential restoring divider for the ALU; the inverse companion of the shift-and-add multiplier.
- Accepts an operand pair plus an operation ID from the input FIFO, using the same valid/ready/start handshake as the multiplier.
- Iterates one quotient bit per shift/subtract pair.
- Presents {id, divide-by-zero flag, remainder, quotient} to the output FIFO and holds it until the write is acknowledged.

Parameters:
- DATA_SIZE, 16, packed result width (remainder + quotient).
- DIV_DATA_SIZE, DATA_SIZE/2, dividend/divisor width (N below).
- ID_SIZE, 8, operation ID width.
- DIV_COUNTER_SIZE (localparam), $clog2(DIV_DATA_SIZE)+1, iteration counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_in  in  DIV_DATA_SIZE  dividend
- b_in  in  DIV_DATA_SIZE  divisor
- id_div  in  ID_SIZE  operation ID
- d_valid_data  in  1  input FIFO holds a valid divide operation
- ready_f_res  in  1  output FIFO not full
- div_written  in  1  output FIFO has stored the current result
- d_ready_data  out  1  divider can accept an operation
- d_valid_res  out  1  result valid for output FIFO
- result_div  out  DATA_SIZE+1+ID_SIZE  {id[24:17], dz[16], rem[15:8], quo[7:0]} at defaults
- start  out  1  registered one-cycle pulse after acceptance; pops the input FIFO

Behaviour:
- Reset (async, any state):
  - state=IDLE; all outputs 0; operand, ID, quotient, remainder and counter registers cleared.
  - An in-flight operation is discarded with no output.
- States: IDLE, INITIAL, SHIFT, SUB, SAVE (3-bit encoding).
- IDLE:
  - d_ready_data = ready_f_res.
  - Accept when d_valid_data & d_ready_data: latch a_in into Q, b_in into D, id_div into the ID reg; clear R and the counter; go to INITIAL.
  - start=1 in the cycle after acceptance only.
  - If d_valid_data is high but ready_f_res is low: no accept, no start.
- INITIAL:
  - If D==0: Q=all ones, R=dividend, dz=1, go to SAVE.
  - Else: dz=0, go to SHIFT.
- SHIFT:
  - {R,Q} shifted left by 1 (Q[0]=0); counter+1; go to SUB.
- SUB:
  - Compute T = {1'b0,R} - {1'b0,D} on N+1 bits.
  - If no borrow: R=T[N-1:0], Q[0]=1.
  - If counter==N, go to SAVE; else go to SHIFT.
- SAVE:
  - d_valid_res=1; result_div stable.
  - On div_written=1: go to IDLE; d_valid_res=0 from the next cycle.
  - Without div_written: stay, holding the result indefinitely.
- div_written outside SAVE is ignored.
- Latency, with accept in cycle t:
  - Normal operation: SAVE / d_valid_res in cycle t+2N+2 (t+18 at defaults).
  - Divide-by-zero: t+2.
- Arithmetic: unsigned; quotient and remainder are each N bits; remainder < divisor whenever the divisor is nonzero.
- result_div keeps its last value after leaving SAVE until the next acceptance overwrites the registers.
- d_ready_data=0 in every state except IDLE; no second operation can be accepted while busy.
- Simultaneous ready_f_res drop in IDLE: acceptance is combinational on the current cycle's values.

Test Plan:
- 100/7 with id=0x3C, ready_f_res=1, div_written held low:
  - d_valid_res rises exactly 18 cycles after accept.
  - result_div = {0x3C, 0, 0x02, 0x0E}, stable until div_written pulses.
  - Then d_valid_res=0 and d_ready_data=1 in the next cycle.
- Boundary operands:
  - 255/1 -> quo=0xFF, rem=0x00.
  - 5/9 -> quo=0x00, rem=0x05.
  - 255/255 -> quo=0x01, rem=0x00.
  - dz=0 in all three.
- 0x2A/0 with id=0x11 -> d_valid_res 2 cycles after accept; result {0x11, 1, 0x2A, 0xFF}.
- Backpressure:
  - d_valid_data=1, ready_f_res=0 for 5 cycles -> d_ready_data=0, start=0, state stays IDLE.
  - Raising ready_f_res -> accept, then start pulses one cycle.
- Reset mid-operation:
  - Assert rst during the 4th SUB of 200/3 -> all outputs 0 immediately (async).
  - After release: IDLE; the next operation 200/3 gives quo=66, rem=2.
- Random regression: 1000 random operand pairs with random div_written delay (0–5 cycles).
  - Quotient and remainder match the reference model.
  - No acceptance while busy.
  - Exactly one start pulse per accept.
